writeback_regfile_stage: RTL and testbench

//  Writeback stage and architectural register file, directly downstream of the execute stage.

---
 rtl/writeback_regfile_stage_if.sv | 37 +++
 rtl/writeback_regfile_stage.sv | 84 ++++++++
 tb/tb_writeback_regfile_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_stage_if.sv
// Bus between the execute/issue side and the writeback register file:
// issue and writeback requests, two operand read ports and the debug/status outputs.
interface writeback_regfile_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rs1_addr;
    logic [DATA_W-1:0] rs1_data;
    logic              rs1_busy;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs2_data;
    logic              rs2_busy;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  retire_cnt;
    logic              wb_err;

    modport master (
        output issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
               rs1_addr, rs2_addr, dbg_addr,
        input  rs1_data, rs1_busy, rs2_data, rs2_busy,
               dbg_data, retire_cnt, wb_err
    );

    modport slave (
        input  issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
               rs1_addr, rs2_addr, dbg_addr,
        output rs1_data, rs1_busy, rs2_data, rs2_busy,
               dbg_data, retire_cnt, wb_err
    );
endinterface

// File: rtl/writeback_regfile_stage.sv
// Writeback stage and architectural register file with write bypass on the
// operand ports, a single-outstanding pending-write scoreboard and a retire counter.
module writeback_regfile_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 32
) (
    input logic                     clk,
    input logic                     rst,
    writeback_regfile_stage_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DATA_W-1:0] dbg_data;
    logic [CNT_W-1:0]  retire_cnt;
    logic              wb_err;

    logic wb_to_zero;
    logic issue_to_zero;

    assign wb_to_zero    = ZR && (bus.wb_rd == '0);
    assign issue_to_zero = ZR && (bus.issue_rd == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending    <= '0;
            dbg_data   <= '0;
            retire_cnt <= '0;
            wb_err     <= 1'b0;
        end else begin
            // Debug read sees the array before this edge's write.
            dbg_data <= regs[bus.dbg_addr];

            if (bus.wb_valid) begin
                if (!wb_to_zero) begin
                    regs[bus.wb_rd] <= bus.wb_data;
                end
                if (!pending[bus.wb_rd] && !wb_to_zero) begin
                    wb_err <= 1'b1;
                end
                pending[bus.wb_rd] <= 1'b0;
                retire_cnt         <= retire_cnt + CNT_W'(1);
            end

            // Placed after the commit clear so a same-edge issue to the same rd wins.
            if (bus.issue_valid && !issue_to_zero) begin
                pending[bus.issue_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.rs1_data = regs[bus.rs1_addr];
        bus.rs1_busy = 1'b0;
        bus.rs2_data = regs[bus.rs2_addr];
        bus.rs2_busy = 1'b0;

        if (ZR && bus.rs1_addr == '0) begin
            bus.rs1_data = '0;
        end else if (bus.wb_valid && bus.wb_rd == bus.rs1_addr) begin
            bus.rs1_data = bus.wb_data;
        end
        bus.rs1_busy = pending[bus.rs1_addr] && !(bus.wb_valid && bus.wb_rd == bus.rs1_addr);

        if (ZR && bus.rs2_addr == '0) begin
            bus.rs2_data = '0;
        end else if (bus.wb_valid && bus.wb_rd == bus.rs2_addr) begin
            bus.rs2_data = bus.wb_data;
        end
        bus.rs2_busy = pending[bus.rs2_addr] && !(bus.wb_valid && bus.wb_rd == bus.rs2_addr);
    end

    assign bus.dbg_data   = dbg_data;
    assign bus.retire_cnt = retire_cnt;
    assign bus.wb_err     = wb_err;

endmodule

// File: tb/tb_writeback_regfile_stage.sv
// Self-checking bench for writeback_regfile_stage: reference model plus a queue of
// expected debug-port values, built with a 4-bit retire counter to reach the wrap.
module tb_writeback_regfile_stage;
    logic clk;
    logic rst;

    writeback_regfile_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) bus ();

    writeback_regfile_stage #(
        .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [3:0]  m_cnt;
    logic        m_err;
    logic [31:0] dbg_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pend = '0;
        m_cnt  = '0;
        m_err  = 1'b0;
        dbg_q.delete();
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input logic wv,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wv && wrd == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input logic wv, input logic [4:0] wrd);
        return m_pend[a] && !(wv && wrd == a);
    endfunction

    // One clock of stimulus: drive at negedge, check combinational outputs, then the edge.
    task automatic cycle(input logic iv, input logic [4:0] ird,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
        logic [31:0] e;
        @(negedge clk);
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.wb_valid    = wv;
        bus.wb_rd       = wrd;
        bus.wb_data     = wd;
        bus.rs1_addr    = a1;
        bus.rs2_addr    = a2;
        bus.dbg_addr    = da;
        #1;
        check_val("rs1_data", bus.rs1_data, exp_data(a1, wv, wrd, wd));
        check_val("rs1_busy", 32'(bus.rs1_busy), 32'(exp_busy(a1, wv, wrd)));
        check_val("rs2_data", bus.rs2_data, exp_data(a2, wv, wrd, wd));
        check_val("rs2_busy", 32'(bus.rs2_busy), 32'(exp_busy(a2, wv, wrd)));
        dbg_q.push_back(m_regs[da]);

        @(posedge clk);
        if (wv) begin
            if (wrd != 5'd0 && !m_pend[wrd]) m_err = 1'b1;
            if (wrd != 5'd0) m_regs[wrd] = wd;
            m_pend[wrd] = 1'b0;
            m_cnt = m_cnt + 4'd1;
        end
        if (iv && ird != 5'd0) m_pend[ird] = 1'b1;
        #1;
        if (dbg_q.size() > 0) begin
            e = dbg_q.pop_front();
            check_val("dbg_data", bus.dbg_data, e);
        end else begin
            check_val("dbg_q_empty", 32'(dbg_q.size()), 32'd1);
        end
        check_val("retire_cnt", 32'(bus.retire_cnt), 32'(m_cnt));
        check_val("wb_err", 32'(bus.wb_err), 32'(m_err));
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cycle(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, a1, a2, a1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.wb_valid = 1'b0;    bus.wb_rd = '0; bus.wb_data = '0;
        bus.rs1_addr = '0; bus.rs2_addr = '0; bus.dbg_addr = '0;
        model_reset();
        #12;
        check_val("rst_cnt", 32'(bus.retire_cnt), 32'd0);
        check_val("rst_err", 32'(bus.wb_err), 32'd0);
        check_val("rst_dbg", bus.dbg_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // RAW on r5: busy while outstanding, bypass on the commit cycle.
        cycle(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 5'd5);
        idle(5'd5, 5'd5);
        cycle(1'b0, 5'd0, 1'b1, 5'd5, 32'h0000_00AA, 5'd5, 5'd5, 5'd5);
        idle(5'd5, 5'd5);
        check_val("r5_after", bus.rs1_data, 32'h0000_00AA);
        check_val("cnt_one", 32'(bus.retire_cnt), 32'd1);

        // Register zero: never pending, writes dropped, no error, still retires.
        cycle(1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check_val("r0_err", 32'(bus.wb_err), 32'd0);

        // Unsolicited writeback to r3 raises the sticky error.
        cycle(1'b0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd3, 5'd3);
        idle(5'd3, 5'd3);
        check_val("r3_err", 32'(bus.wb_err), 32'd1);
        check_val("r3_val", bus.rs1_data, 32'hDEAD_BEEF);

        // Same-edge issue and writeback to r7: data lands, pending survives.
        cycle(1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd7, 5'd7);
        idle(5'd1, 5'd7);
        check_val("r7_busy", 32'(bus.rs2_busy), 32'd1);
        check_val("r7_val", bus.rs2_data, 32'h0000_1234);

        // Random traffic on a small register window to provoke hazards.
        for (int n = 0; n < 80; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        // Counter wrap on the 4-bit build.
        while (m_cnt != 4'd15) begin
            cycle(1'b0, 5'd0, 1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 5'd9);
        end
        cycle(1'b0, 5'd0, 1'b1, 5'd9, 32'h9, 5'd9, 5'd0, 5'd9);
        check_val("cnt_wrap", 32'(bus.retire_cnt), 32'd0);

        // Issue a few so pending bits exist, then reset asynchronously mid-cycle.
        cycle(1'b1, 5'd4, 1'b1, 5'd6, 32'h66, 5'd4, 5'd6, 5'd6);
        cycle(1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 5'd6, 5'd4, 5'd6);
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("arst_cnt", 32'(bus.retire_cnt), 32'd0);
        check_val("arst_err", 32'(bus.wb_err), 32'd0);
        check_val("arst_dbg", bus.dbg_data, 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            #0.1;
            check_val("arst_rs1_data", bus.rs1_data, 32'd0);
            check_val("arst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(5'd4, 5'd6);
        cycle(1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 5'd2, 5'd5, 5'd5);
        cycle(1'b0, 5'd0, 1'b1, 5'd2, 32'h0BAD_F00D, 5'd2, 5'd5, 5'd2);
        idle(5'd2, 5'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
